flag_ctrl: RTL and testbench

FLAG_CTRL -- requirements
Module: flag_ctrl

---
 rtl/flag_pkg.sv | 15 +
 rtl/flag_reg.sv | 24 ++
 rtl/flag_ctrl.sv | 139 +++++++++++++
 tb/tb_flag_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/flag_pkg.sv
// Shared types for the flag controller: ISR-nesting state and the {C,Z} pair
// saved on interrupt entry.
package flag_pkg;

  typedef enum logic {
    NORMAL = 1'b0,
    ISR    = 1'b1
  } state_e;

  typedef struct packed {
    logic c;
    logic z;
  } flag_pair_t;

endpackage

// File: rtl/flag_reg.sv
// Single-bit loadable register with asynchronous active-high reset to 0.
module flag_reg (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ld_i,
  input  logic d_i,
  output logic q_o
);

  logic q_q;

  // NOTE: sequential state is always written with non-blocking (<=) so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= 1'b0;
    end else if (ld_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/flag_ctrl.sv
// Carry/zero flag controller with a shadow stack that saves the live flags on
// interrupt entry and restores them on interrupt return.
module flag_ctrl
  import flag_pkg::*;
#(
  parameter int SHAD_DEPTH = 2
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              ALU_C,
  input  logic                              ALU_Z,
  input  logic                              C_LD,
  input  logic                              Z_LD,
  input  logic                              C_SET,
  input  logic                              C_CLR,
  input  logic                              INT_ACK,
  input  logic                              RETIE,
  output logic                              C_FLAG,
  output logic                              Z_FLAG,
  output logic                              IN_ISR,
  output logic [$clog2(SHAD_DEPTH+1)-1:0]   DEPTH,
  output logic                              ERR
);

  localparam int DW = $clog2(SHAD_DEPTH + 1);
  localparam logic [DW-1:0] FULL_DEPTH = DW'(SHAD_DEPTH);

  logic            c_q, z_q;
  logic            c_ld, z_ld, c_d, z_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic            err_q, err_d;
  state_e          state_q, state_d;

  flag_pair_t      stack_q [SHAD_DEPTH];
  flag_pair_t      rd_pair, wr_pair;
  logic            wr_en;
  logic [DW-1:0]   wr_idx;

  flag_reg u_c_reg (.clk_i(CLK), .rst_i(RST), .ld_i(c_ld), .d_i(c_d), .q_o(c_q));
  flag_reg u_z_reg (.clk_i(CLK), .rst_i(RST), .ld_i(z_ld), .d_i(z_d), .q_o(z_q));

  // Top-of-stack entry (index DEPTH-1); only meaningful when DEPTH>0.
  always_comb begin
    rd_pair = '0;
    for (int i = 0; i < SHAD_DEPTH; i++) begin
      if (depth_q == DW'(i + 1)) rd_pair = stack_q[i];
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path through the if/else tree leaves it unassigned and infers a latch.
  always_comb begin
    depth_d = depth_q;
    err_d   = err_q;
    c_ld    = 1'b0;
    z_ld    = 1'b0;
    c_d     = c_q;
    z_d     = z_q;
    wr_en   = 1'b0;
    wr_idx  = depth_q;
    wr_pair = '{c: c_q, z: z_q};

    if (RETIE && INT_ACK) begin
      // Pop-then-push: the top slot (or slot 0 when empty) takes the live flags.
      c_ld   = 1'b1;
      z_ld   = 1'b1;
      c_d    = 1'b0;
      z_d    = 1'b0;
      wr_en  = 1'b1;
      if (depth_q == '0) begin
        depth_d = DW'(1);
      end else begin
        wr_idx = depth_q - DW'(1);
      end
    end else if (RETIE) begin
      if (depth_q == '0) begin
        err_d = 1'b1;
      end else begin
        c_ld    = 1'b1;
        z_ld    = 1'b1;
        c_d     = rd_pair.c;
        z_d     = rd_pair.z;
        depth_d = depth_q - DW'(1);
      end
    end else if (INT_ACK) begin
      if (depth_q == FULL_DEPTH) begin
        err_d = 1'b1;
      end else begin
        c_ld    = 1'b1;
        z_ld    = 1'b1;
        c_d     = 1'b0;
        z_d     = 1'b0;
        wr_en   = 1'b1;
        depth_d = depth_q + DW'(1);
      end
    end else begin
      c_ld = C_SET | C_CLR | C_LD;
      c_d  = C_SET ? 1'b1 : (C_CLR ? 1'b0 : ALU_C);
      z_ld = Z_LD;
      z_d  = ALU_Z;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      NORMAL:  if (depth_d != '0) state_d = ISR;
      ISR:     if (depth_d == '0) state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      depth_q <= '0;
      err_q   <= 1'b0;
      state_q <= NORMAL;
    end else begin
      depth_q <= depth_d;
      err_q   <= err_d;
      state_q <= state_d;
    end
  end

  // NOTE: stack storage is deliberately not reset; DEPTH gates every read,
  // so stale contents never reach an output.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < SHAD_DEPTH; i++) begin
      if (wr_en && wr_idx == DW'(i)) stack_q[i] <= wr_pair;
    end
  end

  assign C_FLAG = c_q;
  assign Z_FLAG = z_q;
  assign DEPTH  = depth_q;
  assign ERR    = err_q;
  assign IN_ISR = (state_q == ISR);

endmodule

// File: tb/tb_flag_ctrl.sv
// Directed self-checking bench for flag_ctrl with the default SHAD_DEPTH of 2.
module tb_flag_ctrl;

  logic       CLK = 1'b0;
  logic       RST, ALU_C, ALU_Z, C_LD, Z_LD, C_SET, C_CLR, INT_ACK, RETIE;
  logic       C_FLAG, Z_FLAG, IN_ISR, ERR;
  logic [1:0] DEPTH;

  int checks   = 0;
  int failures = 0;

  flag_ctrl #(.SHAD_DEPTH(2)) dut (
    .CLK(CLK), .RST(RST), .ALU_C(ALU_C), .ALU_Z(ALU_Z), .C_LD(C_LD), .Z_LD(Z_LD),
    .C_SET(C_SET), .C_CLR(C_CLR), .INT_ACK(INT_ACK), .RETIE(RETIE),
    .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG), .IN_ISR(IN_ISR), .DEPTH(DEPTH), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic c, input logic z,
                           input logic [1:0] d, input logic isr, input logic err);
    check({tag, ".C"},     8'(C_FLAG), 8'(c));
    check({tag, ".Z"},     8'(Z_FLAG), 8'(z));
    check({tag, ".DEPTH"}, 8'(DEPTH),  8'(d));
    check({tag, ".IN_ISR"},8'(IN_ISR), 8'(isr));
    check({tag, ".ERR"},   8'(ERR),    8'(err));
  endtask

  task automatic clear_inputs();
    {ALU_C, ALU_Z, C_LD, Z_LD, C_SET, C_CLR, INT_ACK, RETIE} = '0;
  endtask

  // Apply the currently driven inputs across one rising edge, then release them.
  task automatic tick();
    @(posedge CLK);
    #1;
    clear_inputs();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #3;
    RST = 1'b0;
    #1;
  endtask

  initial begin
    clear_inputs();
    RST = 1'b1;
    #12;
    check_all("reset", 0, 0, 2'd0, 0, 0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Loads take effect one edge later, with no combinational path.
    C_LD = 1; ALU_C = 1; Z_LD = 1; ALU_Z = 1;
    #1;
    check("no_comb_path.C", 8'(C_FLAG), 8'd0);
    tick();
    check_all("load_cz", 1, 1, 2'd0, 0, 0);

    C_CLR = 1; tick();
    check("clr.C", 8'(C_FLAG), 8'd0);
    check("clr.Z_hold", 8'(Z_FLAG), 8'd1);
    C_SET = 1; C_CLR = 1; tick();
    check("set_and_clr.C", 8'(C_FLAG), 8'd1);
    C_CLR = 1; C_LD = 1; ALU_C = 1; tick();
    check("clr_over_ld.C", 8'(C_FLAG), 8'd0);
    C_SET = 1; C_LD = 1; ALU_C = 0; Z_LD = 1; ALU_Z = 0; tick();
    check_all("set_over_ld", 1, 0, 2'd0, 0, 0);

    // Nested push/pop; flag requests alongside INT_ACK are ignored.
    INT_ACK = 1; C_SET = 1; Z_LD = 1; ALU_Z = 1; tick();
    check_all("push1", 0, 0, 2'd1, 1, 0);
    Z_LD = 1; ALU_Z = 1; tick();
    check_all("live_01", 0, 1, 2'd1, 1, 0);
    INT_ACK = 1; tick();
    check_all("push2", 0, 0, 2'd2, 1, 0);

    // Overflow at full depth.
    C_SET = 1; tick();
    check_all("live_10", 1, 0, 2'd2, 1, 0);
    INT_ACK = 1; tick();
    check_all("overflow", 1, 0, 2'd2, 1, 1);
    RETIE = 1; C_CLR = 1; tick();
    check_all("pop2", 0, 1, 2'd1, 1, 1);
    RETIE = 1; tick();
    check_all("pop1", 1, 0, 2'd0, 0, 1);
    INT_ACK = 1; tick();
    check_all("err_sticky_push", 0, 0, 2'd1, 1, 1);

    // Underflow from reset.
    do_reset();
    check_all("reset2", 0, 0, 2'd0, 0, 0);
    RETIE = 1; tick();
    check_all("underflow", 0, 0, 2'd0, 0, 1);

    // Simultaneous INT_ACK + RETIE with an entry present, then when empty.
    do_reset();
    C_SET = 1; Z_LD = 1; ALU_Z = 1; tick();
    INT_ACK = 1; tick();
    Z_LD = 1; ALU_Z = 1; tick();
    check_all("pre_swap", 0, 1, 2'd1, 1, 0);
    INT_ACK = 1; RETIE = 1; C_SET = 1; tick();
    check_all("swap", 0, 0, 2'd1, 1, 0);
    RETIE = 1; tick();
    check_all("swap_pop", 0, 1, 2'd0, 0, 0);
    INT_ACK = 1; RETIE = 1; tick();
    check_all("both_empty", 0, 0, 2'd1, 1, 0);
    RETIE = 1; tick();
    check_all("both_empty_pop", 0, 1, 2'd0, 0, 0);

    // Asynchronous reset mid-ISR discards the stack.
    INT_ACK = 1; tick();
    INT_ACK = 1; tick();
    C_SET = 1; tick();
    check_all("pre_async", 1, 0, 2'd2, 1, 0);
    #2;
    RST = 1'b1;
    #1;
    check_all("async_rst", 0, 0, 2'd0, 0, 0);
    #1;
    RST = 1'b0;
    RETIE = 1; tick();
    check_all("post_rst_retie", 0, 0, 2'd0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
